// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR command generator.
//   state_t  : FSM state encoding (IDLE, SET pulse, RST pulse, GUARD)
//   DB_CNT_W : debounce counter width
//   PW_CNT_W : pulse/guard down-counter width
package sr_cmd_pkg;

  localparam int DB_CNT_W = 8;
  localparam int PW_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_RST   = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

endpackage

// File: rtl/sr_debounce.sv
// Per-button input conditioning: two-flop synchroniser, debounce counter,
// and press-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous, bouncy button
//   req   : one-cycle pulse on a debounced press (release is ignored)
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic req
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                level;
  logic                level_q;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      // Any sample that agrees with the current level restarts the count,
      // so only an unbroken run of DB_CYCLES differing samples toggles it.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign req = level & ~level_q;

endmodule

// File: rtl/sr_command_gen.sv
// Command generator for the falling-edge SR flip-flop. Debounces the two
// push-buttons and turns press edges into fixed-width, mutually exclusive
// S/R pulses followed by a guard gap.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   set_btn, reset_btn  : raw buttons
//   S, R                : registered pulses to the flip-flop
//   busy                : FSM not idle
//   q_model             : expected flip-flop state
//   conflict, dropped   : sticky error flags (simultaneous press / press while busy)
//
// state    | meaning
// ST_IDLE  | waiting for a press edge
// ST_SET   | S held high for PULSE_W cycles
// ST_RST   | R held high for PULSE_W cycles
// ST_GUARD | S=R=0 forced for GUARD_W cycles
module sr_command_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned PULSE_W   = 1,
  parameter int unsigned GUARD_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic q_model,
  output logic conflict,
  output logic dropped
);

  localparam logic [PW_CNT_W-1:0] PW_LOAD = PW_CNT_W'(PULSE_W - 1);
  localparam logic [PW_CNT_W-1:0] GD_LOAD = PW_CNT_W'((GUARD_W == 0) ? 0 : GUARD_W - 1);

  logic                set_req;
  logic                rst_req;
  state_t              state;
  state_t              state_nxt;
  logic [PW_CNT_W-1:0] cnt;
  logic [PW_CNT_W-1:0] cnt_nxt;
  logic                q_nxt;
  logic                conflict_nxt;
  logic                dropped_nxt;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (set_btn),
    .req   (set_req)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (reset_btn),
    .req   (rst_req)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    q_nxt        = q_model;
    conflict_nxt = conflict;
    dropped_nxt  = dropped;

    // No queueing: anything arriving outside IDLE is lost and flagged.
    if ((state != ST_IDLE) && (set_req || rst_req)) begin
      dropped_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (set_req && rst_req) begin
          conflict_nxt = 1'b1;
        end else if (set_req) begin
          state_nxt = ST_SET;
          cnt_nxt   = PW_LOAD;
          q_nxt     = 1'b1;
        end else if (rst_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = PW_LOAD;
          q_nxt     = 1'b0;
        end
      end
      ST_SET, ST_RST: begin
        if (cnt == '0) begin
          if (GUARD_W == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GUARD;
            cnt_nxt   = GD_LOAD;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    endcase
  end

  // Outputs are flopped from the next state so they change only on the
  // rising edge and are settled at the flip-flop's falling-edge sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      q_model  <= 1'b0;
      conflict <= 1'b0;
      dropped  <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      q_model  <= q_nxt;
      conflict <= conflict_nxt;
      dropped  <= dropped_nxt;
      S        <= (state_nxt == ST_SET);
      R        <= (state_nxt == ST_RST);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule
